// File: rtl/mips_pkg.sv
// mips_pkg: arbiter FSM states, access owner and legal data-memory latency range
package mips_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  typedef enum logic {PIPE, DMA} owner_t;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter saturating at MAX; clr wins over inc; ports clk, rst (async, active-high), clr, inc, count
module sat_counter #(
  parameter int MAX = 4,
  parameter int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else count <= clr ? '0 : (inc && count != W'(MAX)) ? count + 1'b1 : count;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between pipeline (priority) and DMA (anti-starvation); pipe_*/dma_* request sides, mem_* memory side
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_read,
  input  logic        pipe_write,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_stall,
  output logic [31:0] pipe_rdata,
  output logic        pipe_rvalid,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic [31:0] dma_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int LAT = MEM_LAT < MEM_LAT_MIN ? MEM_LAT_MIN : MEM_LAT > MEM_LAT_MAX ? MEM_LAT_MAX : MEM_LAT;
  localparam int CW = $clog2(STARVE_MAX + 1);
  arb_state_t state;
  owner_t owner;
  logic we_q;
  logic [1:0] wcnt;
  logic [31:0] rdata_q;
  logic [CW-1:0] starve;
  logic pipe_req, dma_win, grant, sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic unused_addr_lsbs;
  assign pipe_req = pipe_read | pipe_write;
  assign dma_win = dma_req & (~pipe_req | (starve == CW'(STARVE_MAX)));
  assign grant = (state == IDLE) && (pipe_req || dma_req);
  assign sel_we = dma_win ? dma_we : pipe_write;
  assign sel_addr = dma_win ? dma_addr : pipe_addr;
  assign sel_wdata = dma_win ? dma_wdata : pipe_wdata;
  assign unused_addr_lsbs = ^sel_addr[1:0];
  assign pipe_stall = ~rst & pipe_req & ~(state == DONE && owner == PIPE);
  assign pipe_rdata = rdata_q;
  assign dma_rdata = rdata_q;
  sat_counter #(.MAX(STARVE_MAX), .W(CW)) u_starve (
    .clk  (clk),
    .rst  (rst),
    .clr  (~dma_req | (grant & dma_win)),
    .inc  (grant & ~dma_win & dma_req),
    .count(starve)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      owner <= PIPE;
      we_q <= 1'b0;
      wcnt <= '0;
      rdata_q <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      dma_gnt <= 1'b0;
      pipe_rvalid <= 1'b0;
      dma_done <= 1'b0;
    end else
      case (state)
        IDLE:
          if (grant) begin
            state <= ISSUE;
            owner <= dma_win ? DMA : PIPE;
            we_q <= sel_we;
            mem_en <= 1'b1;
            mem_we <= sel_we;
            mem_addr <= {2'b00, sel_addr[31:2]};
            mem_wdata <= sel_wdata;
            dma_gnt <= dma_win;
          end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          dma_gnt <= 1'b0;
          wcnt <= '0;
          state <= we_q ? DONE : WAIT;
          pipe_rvalid <= we_q && owner == PIPE;
          dma_done <= we_q && owner == DMA;
        end
        WAIT:
          if (wcnt == 2'(LAT - 1)) begin
            rdata_q <= mem_rdata;
            state <= DONE;
            pipe_rvalid <= owner == PIPE;
            dma_done <= owner == DMA;
          end else wcnt <= wcnt + 1'b1;
        DONE: begin
          pipe_rvalid <= 1'b0;
          dma_done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench with a latency-modelled memory, directed timing cases and randomized two-master traffic
module tb_dmem_arbiter;
  localparam int LAT = 2;
  localparam int SMAX = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic pipe_read = 1'b0, pipe_write = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] pipe_addr = '0, pipe_wdata = '0, dma_addr = '0, dma_wdata = '0, mem_rdata = '0;
  logic pipe_stall, pipe_rvalid, dma_gnt, dma_done, mem_en, mem_we;
  logic [31:0] pipe_rdata, dma_rdata, mem_addr, mem_wdata;
  typedef struct {bit rd; logic [31:0] data;} exp_t;
  exp_t pipe_q[$], dma_q[$];
  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] dq [0:4];
  int n_checks = 0, n_fail = 0, ev_cnt = 0, pipe_issues = 0;
  logic [15:0] v_stall, v_en, v_we, v_rv, v_gnt, v_done;
  logic [31:0] a1, rv_data;
  bit gnt_seen;

  dmem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .pipe_read(pipe_read), .pipe_write(pipe_write), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall), .pipe_rdata(pipe_rdata), .pipe_rvalid(pipe_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory model: read data appears LAT cycles after the strobe; monitors pop expectations on completion pulses
  always @(negedge clk) begin
    exp_t e;
    if (mem_en && mem_we) mem[mem_addr[5:0]] = mem_wdata;
    for (int i = LAT; i > 0; i--) dq[i] = dq[i-1];
    dq[0] = (mem_en && !mem_we) ? mem[mem_addr[5:0]] : $urandom;
    mem_rdata = dq[LAT];
    if (mem_en && !dma_gnt) pipe_issues++;
    check("pipe_stall", pipe_stall, (pipe_read | pipe_write) & ~pipe_rvalid & ~rst);
    if (pipe_rvalid) begin
      ev_cnt++;
      if (pipe_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL pipe_rvalid: got unexpected pulse, required none");
      end else begin
        e = pipe_q.pop_front();
        if (e.rd) check("pipe_rdata", pipe_rdata, e.data);
      end
    end
    if (dma_done) begin
      ev_cnt++;
      if (dma_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dma_done: got unexpected pulse, required none");
      end else begin
        e = dma_q.pop_front();
        if (e.rd) check("dma_rdata", dma_rdata, e.data);
      end
    end
  end

  task automatic push_exp(input bit is_dma, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    if (wr) ref_mem[addr[7:2]] = wd;
    e.rd = !wr;
    e.data = ref_mem[addr[7:2]];
    if (is_dma) dma_q.push_back(e); else pipe_q.push_back(e);
  endtask

  task automatic pipe_op(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    int t = 0;
    @(posedge clk); #1;
    pipe_read = rd; pipe_write = wr; pipe_addr = addr; pipe_wdata = wd;
    push_exp(1'b0, wr, addr, wd);
    do begin @(negedge clk); t++; end while (!pipe_rvalid && t < 100);
    check("pipe_op_complete", pipe_rvalid, 1'b1);
  endtask

  task automatic pipe_idle();
    @(posedge clk); #1;
    pipe_read = 1'b0; pipe_write = 1'b0;
  endtask

  task automatic dma_op(input bit wr, input logic [31:0] addr, input logic [31:0] wd, output int issued);
    int t = 0;
    @(posedge clk); #1;
    dma_req = 1'b1; dma_we = wr; dma_addr = addr; dma_wdata = wd;
    push_exp(1'b1, wr, addr, wd);
    do begin @(negedge clk); t++; end while (!dma_gnt && t < 100);
    issued = pipe_issues;
    check("dma_op_granted", dma_gnt, 1'b1);
    @(posedge clk); #1;
    dma_req = 1'b0;
  endtask

  task automatic trace(input int n, input int pipe_cycles, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input bit dreq, input logic [31:0] daddr);
    v_stall = '0; v_en = '0; v_we = '0; v_rv = '0; v_gnt = '0; v_done = '0; gnt_seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        pipe_read = rd; pipe_write = wr; pipe_addr = addr; pipe_wdata = wd;
        dma_req = dreq; dma_we = 1'b0; dma_addr = daddr;
      end
      if (k == pipe_cycles) begin pipe_read = 1'b0; pipe_write = 1'b0; end
      if (gnt_seen) dma_req = 1'b0;
      @(negedge clk);
      v_stall[k] = pipe_stall; v_en[k] = mem_en; v_we[k] = mem_we;
      v_rv[k] = pipe_rvalid; v_gnt[k] = dma_gnt; v_done[k] = dma_done;
      if (k == 1) a1 = mem_addr;
      if (pipe_rvalid) rv_data = pipe_rdata;
      if (dma_gnt) gnt_seen = 1'b1;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, got, t;
    logic [31:0] a;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[16] = 32'hDEAD_BEEF;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < 5; i++) dq[i] = '0;
    pipe_read = 1'b1; dma_req = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pipe_stall", pipe_stall, 1'b0);
    check("rst_pulses", {mem_en, mem_we, pipe_rvalid, dma_gnt, dma_done}, 5'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_rdata", {pipe_rdata, dma_rdata}, 64'h0);
    pipe_read = 1'b0; dma_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    push_exp(1'b0, 1'b0, 32'h40, 0);
    trace(6, 5, 1'b1, 1'b0, 32'h40, 0, 1'b0, 0);
    check("load_stall", v_stall[5:0], 6'b001111);
    check("load_mem_en", v_en[5:0], 6'b000010);
    check("load_rvalid", v_rv[5:0], 6'b010000);
    check("load_mem_addr", a1, 32'h10);
    check("load_data", rv_data, 32'hDEAD_BEEF);

    push_exp(1'b0, 1'b1, 32'h44, 32'h1234);
    trace(4, 3, 1'b0, 1'b1, 32'h44, 32'h1234, 1'b0, 0);
    check("store_mem_we", v_we[3:0], 4'b0010);
    check("store_rvalid", v_rv[3:0], 4'b0100);
    check("store_stall", v_stall[3:0], 4'b0011);
    check("store_mem", mem[17], 32'h1234);

    push_exp(1'b0, 1'b1, 32'h48, 32'hA5A5);
    trace(4, 3, 1'b1, 1'b1, 32'h48, 32'hA5A5, 1'b0, 0);
    check("rdwr_mem_we", v_we[3:0], 4'b0010);
    check("rdwr_rvalid", v_rv[3:0], 4'b0100);
    check("rdwr_mem", mem[18], 32'hA5A5);

    push_exp(1'b0, 1'b0, 32'h4C, 0);
    push_exp(1'b1, 1'b0, 32'h80, 0);
    trace(11, 5, 1'b1, 1'b0, 32'h4C, 0, 1'b1, 32'h80);
    check("both_mem_en", v_en[10:0], 11'b00001000010);
    check("both_dma_gnt", v_gnt[10:0], 11'b00001000000);
    check("both_pipe_rvalid", v_rv[10:0], 11'b00000010000);
    check("both_dma_done", v_done[10:0], 11'b01000000000);
    repeat (2) @(negedge clk);

    base = pipe_issues;
    fork
      dma_op(1'b0, 32'h0000_0084, 0, got);
      begin
        for (int i = 0; i < 6; i++) pipe_op(1'b1, 1'b0, 32'h200 + 4 * i, 0);
        pipe_idle();
      end
    join
    check("starve_pipe_grants", got - base, SMAX);
    repeat (6) @(negedge clk);

    fork
      for (int i = 0; i < 60; i++) begin
        int kind = $urandom_range(0, 2);
        a = $urandom; a[7] = 1'b0;
        pipe_op(kind != 1, kind != 0, a, $urandom);
        if ($urandom_range(0, 1) == 1) pipe_idle();
      end
      for (int i = 0; i < 25; i++) begin
        int dummy;
        repeat ($urandom_range(0, 6)) @(posedge clk);
        a = $urandom; a[7] = 1'b1;
        dma_op($urandom_range(0, 1) == 1, a, $urandom, dummy);
      end
    join
    pipe_idle();
    repeat (12) @(negedge clk);
    check("pipe_queue_drained", pipe_q.size(), 0);
    check("dma_queue_drained", dma_q.size(), 0);

    @(posedge clk); #1;
    pipe_read = 1'b1; pipe_addr = 32'h50;
    t = 0;
    do begin @(negedge clk); t++; end while (!mem_en && t < 20);
    check("abort_issue", mem_en, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("abort_pulses", {mem_en, mem_we, pipe_stall, pipe_rvalid, dma_gnt, dma_done}, 6'b0);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_mem_wdata", mem_wdata, 32'h0);
    check("abort_rdata", {pipe_rdata, dma_rdata}, 64'h0);
    pipe_read = 1'b0;
    base = ev_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_done", ev_cnt - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
